// File: rtl/seq_det_ctrl_pkg.sv
// Shared state encoding, default sizes and config helpers for seq_det_ctrl.
// Latency: n/a (types and constants only). Backpressure: n/a.
package seq_det_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int PAT_MAX_DEF = 8;
  localparam int LEN_W_DEF   = $clog2(PAT_MAX_DEF + 1);

  // A zero length would match every bit, so it is promoted to one.
  function automatic int clamp_len(input int len, input int pat_max);
    if (len < 1) return 1;
    if (len > pat_max) return pat_max;
    return len;
  endfunction

endpackage

// File: rtl/seq_bit_matcher.sv
// Overlapping serial pattern matcher: keeps bit history and fill level.
// Latency: hit is combinational on the bit being consumed. Backpressure: none, one bit per bit_vld.
module seq_bit_matcher
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_vld,
  input  logic               bit_in,
  input  logic               clr,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [PAT_MAX-1:0] history;
  logic [PAT_MAX-1:0] hist_nxt;
  logic [PAT_MAX-1:0] mask;
  logic [LEN_W-1:0]   fill;

  // The compare includes the bit arriving this cycle, hence hist_nxt and fill+1.
  always_comb begin
    hist_nxt = PAT_MAX'({history, bit_in});
    mask     = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = bit_vld && ((int'(fill) + 1) >= int'(len)) &&
          ((hist_nxt & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (bit_vld) begin
      history <= hist_nxt;
      if (fill != LEN_W'(PAT_MAX)) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit serializer feeding a programmable overlapping matcher, with match counter and sticky irq.
// Latency: match_pulse one cycle after the matching bit; one word per DATA_W+1 cycles (DATA_W with SEQ_DET_CTRL_PIPE_EN).
// Backpressure: in_ready low while shifting; SEQ_DET_CTRL_PIPE_EN also raises it on the last shift cycle.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [PAT_MAX-1:0]           cfg_pat,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]             cfg_thresh,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         match_pulse,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         irq,
  input  logic                         irq_clr,
  output logic                         busy
);

  localparam int LEN_W  = $clog2(PAT_MAX + 1);
  localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
`ifdef SEQ_DET_CTRL_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  // With pipelining and single-bit words the first shift cycle is also the last.
  localparam bit RDY_AT_START = PIPE && (DATA_W == 1);

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [BIDX_W-1:0]  bit_idx;
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   thresh;
  logic               cfg_ok;
  logic               accept;
  logic               shift_vld;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;

  assign cfg_ok    = cfg_we && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign shift_vld = (state == ST_SHIFT);
  assign cnt_inc   = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + 1'b1;

  seq_bit_matcher #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_vld (shift_vld),
    .bit_in  (shreg[DATA_W-1]),
    .clr     (cfg_ok),
    .pattern (pattern),
    .len     (len),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      pattern     <= '0;
      len         <= LEN_W'(1);
      thresh      <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      irq         <= 1'b0;
    end else begin
      match_pulse <= hit;

      // Config and matching never coincide: config lands only in IDLE, hits only in SHIFT.
      if (cfg_ok) begin
        pattern   <= cfg_pat;
        len       <= LEN_W'(clamp_len(int'(cfg_len), PAT_MAX));
        thresh    <= cfg_thresh;
        match_cnt <= '0;
        irq       <= 1'b0;
      end else begin
        if (hit) match_cnt <= cnt_inc;
        if (hit && (thresh != '0) && (cnt_inc == thresh) && (match_cnt != thresh)) begin
          irq <= 1'b1;
        end else if (irq_clr) begin
          irq <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            shreg    <= in_data;
            bit_idx  <= '0;
            state    <= ST_SHIFT;
            busy     <= 1'b1;
            in_ready <= RDY_AT_START;
          end
        end
        ST_SHIFT: begin
          shreg   <= shreg << 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_IDX) begin
            if (accept) begin
              shreg    <= in_data;
              bit_idx  <= '0;
              in_ready <= RDY_AT_START;
            end else begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end
          end else begin
            in_ready <= PIPE && (bit_idx == LAST_IDX - 1'b1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Table-driven bench for seq_det_ctrl with a small expected-result queue.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cfg_we, in_valid, irq_clr;
  logic [7:0] cfg_pat, cfg_thresh, in_data;
  logic [3:0] cfg_len;
  logic       in_ready, match_pulse, irq, busy;
  logic [7:0] match_cnt;

  logic       rst2_n, cfg_we2, in_valid2;
  logic [7:0] in_data2;
  logic       in_ready2, pulse2, irq2, busy2;
  logic [1:0] cnt2;

  int checks   = 0;
  int failures = 0;

  seq_det_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr),
    .busy        (busy)
  );

  seq_det_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst2_n),
    .cfg_we      (cfg_we2),
    .cfg_pat     (8'h01),
    .cfg_len     (4'd1),
    .cfg_thresh  (2'd0),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .in_data     (in_data2),
    .match_pulse (pulse2),
    .match_cnt   (cnt2),
    .irq         (irq2),
    .irq_clr     (1'b0),
    .busy        (busy2)
  );

  typedef struct {
    bit         do_cfg;
    bit         same_cyc;
    bit         cfg_mid;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] thr;
    logic [7:0] word;
    int         clr_k;
    logic [7:0] exp_pulse;  // bit [7-k] = pulse for serialized bit k
    logic [7:0] exp_irq;    // irq level sampled after bit k
    logic [7:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] pulse;
    logic [7:0] irqm;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] pm, im;
    logic [8:0] rt, bt;
    exp_t       e;
    int         w;
    if (v.do_cfg && !v.same_cyc) begin
      cfg_pat = v.pat; cfg_len = v.len; cfg_thresh = v.thr; cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      check($sformatf("v%0d cfg_clear", idx), {match_cnt, irq}, 32'h0);
    end
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL v%0d ready_timeout: in_ready=%b required 1", idx, in_ready);
    end
    if (v.do_cfg && v.same_cyc) begin
      cfg_pat = v.pat; cfg_len = v.len; cfg_thresh = v.thr; cfg_we = 1'b1;
    end
    in_data  = v.word;
    in_valid = 1'b1;
    sb.push_back('{v.exp_pulse, v.exp_irq, v.exp_cnt});
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    rt[0] = in_ready;
    bt[0] = busy;
    for (int k = 0; k < 8; k++) begin
      irq_clr = (k == v.clr_k);
      if (v.cfg_mid && k == 2) begin
        cfg_pat = v.pat; cfg_len = v.len; cfg_thresh = v.thr; cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      pm[7-k]  = match_pulse;
      im[7-k]  = irq;
      rt[k+1]  = in_ready;
      bt[k+1]  = busy;
    end
    irq_clr = 1'b0;
    cfg_we  = 1'b0;
    e = sb.pop_front();
    check($sformatf("v%0d pulses", idx), pm, e.pulse);
    check($sformatf("v%0d irq_trace", idx), im, e.irqm);
    check($sformatf("v%0d match_cnt", idx), match_cnt, e.cnt);
    check($sformatf("v%0d ready_trace", idx), rt, 9'h100);
    check($sformatf("v%0d busy_trace", idx), bt, 9'h0FF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse;
    //            cfg same mid  pat    len   thr   word   clr  pulse  irq    cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h0D, 4'd4,  8'd0, 8'hDA, -1, 8'h12, 8'h00, 8'd2};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h0D, 4'd4,  8'd0, 8'h01, -1, 8'h00, 8'h00, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h0D, 4'd4,  8'd0, 8'hA0, -1, 8'h20, 8'h00, 8'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h0D, 4'd4,  8'd3, 8'hDA, -1, 8'h12, 8'h00, 8'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h0D, 4'd4,  8'd3, 8'hDA,  6, 8'h12, 8'h1C, 8'd4};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h03, 4'd2,  8'd0, 8'hDA, -1, 8'h12, 8'h00, 8'd6};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h03, 4'd2,  8'd0, 8'hFF, -1, 8'h7F, 8'h00, 8'd7};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h03, 4'd2,  8'd2, 8'hFF, -1, 8'h7F, 8'h3F, 8'd7};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h01, 4'd0,  8'd0, 8'h80, -1, 8'h80, 8'h00, 8'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 4'd15, 8'd0, 8'hFF, -1, 8'h01, 8'h00, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'hFF, 4'd15, 8'd0, 8'h7F, -1, 8'h00, 8'h00, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hFF, 4'd15, 8'd0, 8'hFF, -1, 8'hFF, 8'h00, 8'd9};

    rst_n = 1'b0; rst2_n = 1'b0;
    cfg_we = 1'b0; in_valid = 1'b0; irq_clr = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_thresh = '0; in_data = '0;
    cfg_we2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {in_ready, match_pulse, match_cnt, irq, busy}, 32'h0);
    rst_n = 1'b1; rst2_n = 1'b1;
    #1;
    check("ready_release_cycle", in_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Saturating counter on the CNT_W=2 instance, then asynchronous reset mid-word.
    cfg_we2 = 1'b1;
    @(negedge clk);
    cfg_we2 = 1'b0;
    in_data2 = 8'hFF; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pulse2) npulse++;
    end
    check("sat_pulse_count", npulse, 8);
    check("sat_match_cnt", cnt2, 2'd3);

    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    check("async_reset_outputs", {in_ready2, pulse2, cnt2, irq2, busy2}, 32'h0);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst2_n = 1'b1;
      if (pulse2) npulse++;
    end
    check("no_pulse_after_reset", npulse, 0);
    check("cnt_after_reset", {cnt2, busy2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Controller that sequences a bit-serial, overlapping pattern matcher from a word-wide valid/ready stream.
- Accepts DATA_W-bit words and serializes them MSB-first, one bit per clock, into a programmable pattern matcher (1..PAT_MAX bits).
- Counts matches and raises a sticky threshold interrupt.
- Sits between a parallel producer and the detection/status logic; replaces fixed-pattern Mealy detectors.

Parameters:
- DATA_W, 8, input word width; bits serialized per accepted word.
- PAT_MAX, 8, maximum pattern length in bits.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe; accepted only in IDLE.
- cfg_pat  in  PAT_MAX  pattern; bit [cfg_len-1] is matched first (oldest), bit 0 last (newest).
- cfg_len  in  $clog2(PAT_MAX+1)  pattern length.
- cfg_thresh  in  CNT_W  interrupt threshold; 0 disables the interrupt.
- in_valid  in  1  producer word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_W  word, serialized MSB-first.
- match_pulse  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  saturating match count.
- irq  out  1  sticky threshold interrupt.
- irq_clr  in  1  clears irq.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE, in_ready=0 in the reset cycle, then 1.
  - match_pulse=0, match_cnt=0, irq=0, busy=0.
  - history=0, fill=0, pattern=0, len=1, thresh=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the shift register, set bit_idx=0, go to SHIFT.
  - SHIFT: busy=1, in_ready=0. Each cycle, shift bit [DATA_W-1-bit_idx] into history (history <= {history, bit}) and increment bit_idx. After the DATA_W-th bit, return to IDLE.
  - Throughput: one word per DATA_W+1 cycles.
- Matching:
  - A match occurs on the cycle a bit is consumed when fill >= len and history[len-1:0] (including the new bit) == pattern[len-1:0].
  - Overlap is allowed; history persists across words.
  - fill increments per bit and saturates at PAT_MAX.
  - match_pulse is registered: high the cycle after the matching bit is consumed.
- Config:
  - cfg_we in IDLE latches pattern, len, and thresh, and clears history, fill, match_cnt, and irq.
  - cfg_we in SHIFT is ignored entirely.
  - cfg_len=0 is treated as 1; cfg_len>PAT_MAX is clamped to PAT_MAX.
  - cfg_we and in_valid in the same IDLE cycle: config applies first, and the word is accepted and matched under the new config.
- Counter: increments on each match and saturates at 2^CNT_W-1 (no wrap).
- irq:
  - Set on the cycle match_cnt transitions to equal thresh (thresh!=0). Asserted together with match_pulse.
  - irq_clr clears it. Simultaneous set and irq_clr: set wins.
  - Not re-set while the count stays at or above thresh. A new cfg_we rearms it.
- Reset mid-SHIFT: the word is discarded and all state is cleared; no partial match_pulse.

Optional Feature:
- Macro: SEQ_DET_CTRL_PIPE_EN.
- Defined: in_ready also asserts in the last SHIFT cycle (bit_idx==DATA_W-1). A word accepted there starts SHIFT in the next cycle without passing through IDLE. Throughput is one word per DATA_W cycles. cfg_we is still honoured only in IDLE.
- Undefined: in_ready is high only in IDLE, as specified above.

Decomposition:
- Package seq_det_ctrl_pkg:
  - state encoding localparams (ST_IDLE, ST_SHIFT).
  - default PAT_MAX and the length-width constant.
  - len-clamp function.
- Sub-module seq_bit_matcher holds history, fill, and the compare logic.
  - Inputs: bit_vld, bit_in, clr, pattern, len.
  - Output: hit (combinational).
- Top level holds the FSM, serializer, counter, and irq logic.

Test Plan:
- Config pat=4'b1101, len=4, thresh=0; send 0xDA (1101_1010) -> match_pulse at bits 4 and 7 (overlap), match_cnt=2, irq=0, in_ready low for 8 cycles.
- Same config; send 0x01 then 0xA0 -> exactly one match_pulse, on the 3rd bit of the second word (match spans the word boundary), match_cnt=1.
- pat=1101, len=4, thresh=3; send 0xDA, 0xDA:
  - match_cnt=4; irq rises with the 3rd pulse (bit 12).
  - Pulse irq_clr coincident with the 4th match -> irq=0 afterwards.
- cfg_we with new pattern 2'b11, len=2 asserted mid-SHIFT -> ignored, old counting continues. Repeated in IDLE -> match_cnt=0, irq=0; send 0xFF -> 7 matches.
- CNT_W=2, pat=1, len=1; send 0xFF -> match_cnt saturates at 3, match_pulse count=8. Assert rst_n=0 mid-word -> all outputs 0 immediately (async), no further pulses.
